// File: rtl/tx_frame_buffer.sv
// ---------------------------------------------------------------------------
// tx_frame_buffer
//   Frame buffer between the channel serializer and the SFP transmit stream.
//   Words arrive one per cycle with no handshake and are held in a circular
//   buffer. The buffer normally forwards only complete frames (STORE mode).
//   It switches to cut-through (CUT mode) when it fills up without holding a
//   complete frame, so that an oversized frame cannot deadlock it.
//
// Ports
//   TX_ACLK          in   clock, rising edge
//   TX_ARESETN       in   synchronous active-low reset
//   SERIALIZED_DATA  in   write data word
//   WR_EN            in   write qualifier (no ready back)
//   WR_LAST          in   last word of frame, qualified by WR_EN
//   WAIT_OUT         out  registered backpressure (occupancy >= WAIT_THRESHOLD)
//   M_AXIS_TDATA     out  stream data (head entry)
//   M_AXIS_TVALID    out  stream valid
//   M_AXIS_TREADY    in   stream ready
//   M_AXIS_TLAST     out  stream last (stored WR_LAST of head entry)
//   FRAME_CNT        out  number of complete frames held
//   OVERFLOW         out  sticky: a write arrived while full and was dropped
// ---------------------------------------------------------------------------
module tx_frame_buffer #(
  parameter int TX_RX_M_AXIS_WIDTH = 64,
  parameter int FIFO_DEPTH_LOG2    = 5,
  parameter int WAIT_THRESHOLD     = 24
) (
  input  logic                          TX_ACLK,
  input  logic                          TX_ARESETN,
  input  logic [TX_RX_M_AXIS_WIDTH-1:0] SERIALIZED_DATA,
  input  logic                          WR_EN,
  input  logic                          WR_LAST,
  output logic                          WAIT_OUT,
  output logic [TX_RX_M_AXIS_WIDTH-1:0] M_AXIS_TDATA,
  output logic                          M_AXIS_TVALID,
  input  logic                          M_AXIS_TREADY,
  output logic                          M_AXIS_TLAST,
  output logic [FIFO_DEPTH_LOG2:0]      FRAME_CNT,
  output logic                          OVERFLOW
);

  localparam int W     = TX_RX_M_AXIS_WIDTH;
  localparam int L     = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 2 ** L;
  localparam logic [L:0] DEPTH_OCC = (L + 1)'(DEPTH);
  localparam logic [L:0] WAIT_OCC  = (L + 1)'(WAIT_THRESHOLD);

  typedef enum logic {STORE, CUT} mode_t;

  // Each entry is {last, data}.
  logic [W:0]   mem_q [DEPTH];

  logic [L-1:0] wr_ptr_q, wr_ptr_d;
  logic [L-1:0] rd_ptr_q, rd_ptr_d;
  logic [L:0]   occ_q, occ_d;
  logic [L:0]   frame_cnt_q, frame_cnt_d;
  logic         overflow_q, overflow_d;
  logic         wait_q, wait_d;
  mode_t        state_q, state_d;

  logic [W:0]   head;
  logic         full;
  logic         wr_acc;
  logic         rd_acc;
  logic         fc_inc;
  logic         fc_dec;

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    occ_d         = occ_q;
    frame_cnt_d   = frame_cnt_q;
    overflow_d    = overflow_q;
    state_d       = state_q;

    full          = (occ_q == DEPTH_OCC);
    M_AXIS_TDATA  = head[W-1:0];
    M_AXIS_TLAST  = head[W];
    // In STORE mode the head is always the start of a frame, so a nonzero
    // frame count means the head frame is complete and may be released.
    if (state_q == CUT) begin
      M_AXIS_TVALID = (occ_q != '0);
    end else begin
      M_AXIS_TVALID = (occ_q != '0) && (frame_cnt_q != '0);
    end

    // Fullness is judged on the registered occupancy: a read in the same
    // cycle does not make room for a write.
    wr_acc = WR_EN && !full;
    rd_acc = M_AXIS_TVALID && M_AXIS_TREADY;
    fc_inc = wr_acc && WR_LAST;
    fc_dec = rd_acc && M_AXIS_TLAST;

    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({wr_acc, rd_acc})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    case ({fc_inc, fc_dec})
      2'b10:   frame_cnt_d = frame_cnt_q + 1'b1;
      2'b01:   frame_cnt_d = frame_cnt_q - 1'b1;
      default: frame_cnt_d = frame_cnt_q;
    endcase

    if (WR_EN && full) overflow_d = 1'b1;

    wait_d = (occ_d >= WAIT_OCC);

    case (state_q)
      STORE: if (full && frame_cnt_q == '0) state_d = CUT;
      CUT:   if (rd_acc && M_AXIS_TLAST)    state_d = STORE;
      default: state_d = STORE;
    endcase
  end

  always_ff @(posedge TX_ACLK) begin
    if (!TX_ARESETN) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
      wait_q      <= 1'b0;
      state_q     <= STORE;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
      wait_q      <= wait_d;
      state_q     <= state_d;
    end
  end

  // Storage is never cleared; reset only empties the buffer via the pointers.
  always_ff @(posedge TX_ACLK) begin
    if (TX_ARESETN && wr_acc) begin
      mem_q[wr_ptr_q] <= {WR_LAST, SERIALIZED_DATA};
    end
  end

  assign FRAME_CNT = frame_cnt_q;
  assign OVERFLOW  = overflow_q;
  assign WAIT_OUT  = wait_q;

endmodule

// File: tb/tb_tx_frame_buffer.sv
module tb_tx_frame_buffer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [63:0] wr_data = '0;
  logic        wr_en = 1'b0;
  logic        wr_last = 1'b0;
  logic        wait_out;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tready = 1'b0;
  logic        tlast;
  logic [5:0]  frame_cnt;
  logic        overflow;

  int checks = 0;
  int passed = 0;

  // Reference model state
  logic [64:0] sb_q[$];
  int          m_fc = 0;
  bit          m_cut = 0;
  bit          m_wait = 0;
  bit          m_ovf = 0;
  bit          mon_en = 0;

  tx_frame_buffer #(
    .TX_RX_M_AXIS_WIDTH(64),
    .FIFO_DEPTH_LOG2(5),
    .WAIT_THRESHOLD(24)
  ) dut (
    .TX_ACLK(clk),
    .TX_ARESETN(rstn),
    .SERIALIZED_DATA(wr_data),
    .WR_EN(wr_en),
    .WR_LAST(wr_last),
    .WAIT_OUT(wait_out),
    .M_AXIS_TDATA(tdata),
    .M_AXIS_TVALID(tvalid),
    .M_AXIS_TREADY(tready),
    .M_AXIS_TLAST(tlast),
    .FRAME_CNT(frame_cnt),
    .OVERFLOW(overflow)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Monitor and model: compare outputs mid-cycle, then advance the model
  // with the inputs that the coming rising edge will see.
  always @(negedge clk) begin
    bit exp_valid, hs, full, head_last, acc;
    logic [64:0] head;
    if (mon_en) begin
      exp_valid = m_cut ? (sb_q.size() > 0) : (sb_q.size() > 0 && m_fc > 0);
      check_value("tvalid", {63'b0, tvalid}, {63'b0, exp_valid});
      check_value("frame_cnt", {58'b0, frame_cnt}, 64'(m_fc));
      check_value("wait_out", {63'b0, wait_out}, {63'b0, m_wait});
      check_value("overflow", {63'b0, overflow}, {63'b0, m_ovf});
      hs = exp_valid && tready;
      head_last = 1'b0;
      if (sb_q.size() > 0) begin
        head = sb_q[0];
        head_last = head[64];
      end
      if (hs) begin
        check_value("tdata", tdata, head[63:0]);
        check_value("tlast", {63'b0, tlast}, {63'b0, head_last});
        $display("out  data=%016h last=%0b", tdata, tlast);
      end
      if (!rstn) begin
        sb_q.delete();
        m_fc = 0; m_cut = 0; m_wait = 0; m_ovf = 0;
      end else begin
        full = (sb_q.size() == 32);
        if (!m_cut && full && m_fc == 0) m_cut = 1;
        else if (m_cut && hs && head_last) m_cut = 0;
        acc = wr_en && !full;
        if (wr_en && full) m_ovf = 1;
        if (hs) begin
          void'(sb_q.pop_front());
          if (head_last) m_fc--;
        end
        if (acc) begin
          sb_q.push_back({wr_last, wr_data});
          if (wr_last) m_fc++;
        end
        m_wait = (sb_q.size() >= 24);
      end
    end
  end

  // All tasks are entered one time unit after a rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_word(input logic [63:0] d, input logic l);
    wr_en = 1'b1; wr_data = d; wr_last = l;
    $display("in   data=%016h last=%0b", d, l);
    step(1);
    wr_en = 1'b0; wr_last = 1'b0;
  endtask

  initial begin
    logic [63:0] held;
    rstn = 1'b0;
    step(2);
    mon_en = 1'b1;
    check_value("rst_tvalid", {63'b0, tvalid}, 64'd0);
    check_value("rst_fc", {58'b0, frame_cnt}, 64'd0);
    rstn = 1'b1;
    step(1);

    // 3-word frame, ready high: nothing until C, then A,B,C back to back
    tready = 1'b1;
    write_word(64'hA, 1'b0);
    check_value("sf_hold_a", {63'b0, tvalid}, 64'd0);
    write_word(64'hB, 1'b0);
    check_value("sf_hold_b", {63'b0, tvalid}, 64'd0);
    write_word(64'hC, 1'b1);
    check_value("sf_release", {63'b0, tvalid}, 64'd1);
    check_value("sf_head", tdata, 64'hA);
    step(5);

    // Two frames while stalled
    tready = 1'b0;
    for (int i = 0; i < 3; i++) write_word(64'h100 + 64'(i), i == 2);
    for (int i = 0; i < 2; i++) write_word(64'h200 + 64'(i), i == 1);
    held = tdata;
    step(10);
    check_value("stall_fc", {58'b0, frame_cnt}, 64'd2);
    check_value("stall_data", tdata, held);
    tready = 1'b1;
    step(8);

    // Wait threshold
    tready = 1'b0;
    for (int i = 0; i < 24; i++) write_word(64'h300 + 64'(i), 1'b0);
    check_value("wait_on", {63'b0, wait_out}, 64'd1);
    write_word(64'h318, 1'b1);
    tready = 1'b1;
    step(2);
    check_value("wait_off", {63'b0, wait_out}, 64'd0);
    step(26);

    // Oversized frame: fill, overflow, cut-through drain
    tready = 1'b0;
    for (int i = 0; i < 40; i++) write_word(64'h400 + 64'(i), 1'b0);
    check_value("ovf_set", {63'b0, overflow}, 64'd1);
    check_value("cut_valid", {63'b0, tvalid}, 64'd1);
    tready = 1'b1;
    step(34);
    check_value("cut_drained", {63'b0, tvalid}, 64'd0);
    write_word(64'h500, 1'b0);
    write_word(64'h501, 1'b1);
    step(4);

    // Coincident last write and last read
    tready = 1'b0;
    write_word(64'h600, 1'b0);
    write_word(64'h601, 1'b1);
    tready = 1'b1;
    write_word(64'h700, 1'b0);
    write_word(64'h701, 1'b1);
    check_value("coinc_fc", {58'b0, frame_cnt}, 64'd1);
    step(4);

    // Reset with 5 words buffered, write attempted during reset
    tready = 1'b0;
    for (int i = 0; i < 5; i++) write_word(64'h800 + 64'(i), i == 4);
    rstn = 1'b0;
    write_word(64'h8FF, 1'b1);
    rstn = 1'b1;
    check_value("rst2_tvalid", {63'b0, tvalid}, 64'd0);
    check_value("rst2_fc", {58'b0, frame_cnt}, 64'd0);
    check_value("rst2_ovf", {63'b0, overflow}, 64'd0);
    check_value("rst2_wait", {63'b0, wait_out}, 64'd0);
    tready = 1'b1;
    for (int i = 0; i < 3; i++) write_word(64'h900 + 64'(i), i == 2);
    step(6);

    check_value("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
